icache_refill_arb: RTL and testbench

ICACHE_REFILL_ARB -- requirements
Module: icache_refill_arb

---
 rtl/icache_refill_arb.sv | 123 ++++++++++++
 tb/tb_icache_refill_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_arb.sv
// Round-robin refill arbiter: shares one in-order memory read port among NUM_REQ
// iCache miss ports and routes the returned lines back via an in-order ID FIFO.
module icache_refill_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0][31:0]   i_req_addr,
  output logic [NUM_REQ-1:0]         o_req_ack,
  output logic [NUM_REQ-1:0]         o_resp_valid,
  output logic [DATA_WIDTH-1:0]      o_resp_data,
  output logic                       o_mm_rden,
  output logic [31:0]                o_mm_addr,
  input  logic                       i_mm_gnt,
  input  logic                       i_mm_rvalid,
  input  logic [DATA_WIDTH-1:0]      i_mm_rdata,
  output logic [NUM_REQ-1:0]         o_pending,
  output logic                       o_busy,
  output logic [1:0]                 o_err
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [NUM_REQ-1:0] pending;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_fifo [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [CNT_W-1:0]   count;
  logic [WD_W-1:0]    wdog;

  logic [NUM_REQ-1:0] elig;
  logic               sel_found;
  logic [ID_W-1:0]    sel_idx;
  logic [ID_W-1:0]    cand;
  logic               issue;
  logic               pop;
  logic [ID_W-1:0]    head_id;
  logic [CNT_W-1:0]   count_nxt;
  logic [NUM_REQ-1:0] set_vec;
  logic [NUM_REQ-1:0] clr_vec;

  // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    elig      = i_req & ~pending;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    issue     = i_mm_gnt & sel_found & (count < CNT_W'(DEPTH));
    pop       = i_mm_rvalid & (count != '0);
    head_id   = id_fifo[rptr];
    count_nxt = count + CNT_W'(issue) - CNT_W'(pop);
    set_vec   = issue ? (NUM_REQ'(1) << sel_idx) : '0;
    clr_vec   = pop ? (NUM_REQ'(1) << head_id) : '0;
  end

  // ID storage needs no reset; validity is tracked by count and the pointers.
  always_ff @(posedge i_clk) begin
    if (!i_rst && issue) id_fifo[wptr] <= sel_idx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mm_rden    <= 1'b0;
      o_mm_addr    <= '0;
      o_req_ack    <= '0;
      o_resp_valid <= '0;
      o_resp_data  <= '0;
      pending      <= '0;
      rr_ptr       <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wdog         <= '0;
      o_busy       <= 1'b0;
      o_err        <= '0;
    end else begin
      o_mm_rden    <= issue;
      o_req_ack    <= set_vec;
      o_resp_valid <= clr_vec;
      pending      <= (pending | set_vec) & ~clr_vec;
      count        <= count_nxt;
      o_busy       <= (count_nxt != '0);
      if (issue) begin
        o_mm_addr <= i_req_addr[sel_idx];
        rr_ptr    <= (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
        wptr      <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        o_resp_data <= i_mm_rdata;
        rptr        <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
      if (i_mm_rvalid && count == '0) o_err[0] <= 1'b1;
      // Watchdog saturates at TIMEOUT; the flag is set on the step that reaches it.
      if (count == '0 || i_mm_rvalid) begin
        wdog <= '0;
      end else if (wdog != WD_W'(TIMEOUT)) begin
        wdog <= wdog + 1'b1;
        if (wdog == WD_W'(TIMEOUT - 1)) o_err[1] <= 1'b1;
      end
    end
  end

  assign o_pending = pending;

endmodule

// File: tb/tb_icache_refill_arb.sv
// Bench for icache_refill_arb: table-driven arbitration scenarios with an in-order
// memory model, a response scoreboard, and hand sequences for reset/error corners.
module tb_icache_refill_arb;

  logic              clk;
  logic              i_rst;
  logic [3:0]        i_req;
  logic [3:0][31:0]  addr_tab;
  logic [3:0]        o_req_ack;
  logic [3:0]        o_resp_valid;
  logic [127:0]      o_resp_data;
  logic              o_mm_rden;
  logic [31:0]       o_mm_addr;
  logic              i_mm_gnt;
  logic              i_mm_rvalid;
  logic [127:0]      i_mm_rdata;
  logic [3:0]        o_pending;
  logic              o_busy;
  logic [1:0]        o_err;

  icache_refill_arb #(
    .NUM_REQ(4), .DATA_WIDTH(128), .DEPTH(2), .TIMEOUT(255)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_addr(addr_tab),
    .o_req_ack(o_req_ack), .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data),
    .o_mm_rden(o_mm_rden), .o_mm_addr(o_mm_addr), .i_mm_gnt(i_mm_gnt),
    .i_mm_rvalid(i_mm_rvalid), .i_mm_rdata(i_mm_rdata), .o_pending(o_pending),
    .o_busy(o_busy), .o_err(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int unsigned fire; logic [31:0] addr; } mrd_t;
  typedef struct { int unsigned due; logic [3:0] vec; logic [127:0] data; } sb_t;
  typedef struct {
    logic [3:0]      req;
    logic [7:0]      gnt;
    int unsigned     lat, win, ng, nr;
    logic [4:0][1:0] gid;
    logic [4:0][3:0] gcyc;
    logic [3:0][3:0] rvec;
    logic            busy;
    logic [3:0]      pend;
  } vec_t;

  mrd_t        mem_q [$];
  sb_t         sb [$];
  int          grants [$];
  int unsigned gcyc [$];
  logic [3:0]  resps [$];
  vec_t        tbl [3];

  int unsigned cyc, base, lat;
  int          n_pass, n_total;
  logic        man_rv, man_expect;
  logic [31:0] man_addr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'h0000_1234};
  endfunction

  function automatic logic [3:0] onehot_of(input logic [31:0] a);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) if (addr_tab[k] == a) v = 4'(1) << k;
    return v;
  endfunction

  // One clock: observe outputs 1 time unit after the edge, then drive memory side.
  task automatic tick();
    int id;
    @(posedge clk);
    #1;
    cyc++;
    if (o_mm_rden) begin
      id = -1;
      for (int k = 3; k >= 0; k--) if (o_req_ack[k]) id = k;
      chk("ack_onehot", 128'($countones(o_req_ack)), 1);
      if (id >= 0) chk("rden_addr", o_mm_addr, addr_tab[id]);
      grants.push_back(id);
      gcyc.push_back(cyc - base);
      if (lat != 0) mem_q.push_back('{fire: cyc + lat - 1, addr: o_mm_addr});
    end else if (o_req_ack != '0) begin
      chk("stray_ack", o_req_ack, 0);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("resp_valid", o_resp_valid, sb[0].vec);
      chk("resp_data", o_resp_data, sb[0].data);
      resps.push_back(o_resp_valid);
      void'(sb.pop_front());
    end else if (o_resp_valid != '0) begin
      chk("stray_resp", o_resp_valid, 0);
    end
    i_mm_rvalid = 1'b0;
    if (man_rv) begin
      i_mm_rvalid = 1'b1;
      i_mm_rdata  = data_of(man_addr);
      if (man_expect)
        sb.push_back('{due: cyc + 1, vec: onehot_of(man_addr), data: data_of(man_addr)});
      man_rv = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].fire <= cyc) begin
      i_mm_rvalid = 1'b1;
      i_mm_rdata  = data_of(mem_q[0].addr);
      sb.push_back('{due: cyc + 1, vec: onehot_of(mem_q[0].addr), data: data_of(mem_q[0].addr)});
      void'(mem_q.pop_front());
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_req = '0; i_mm_gnt = 1'b0; man_rv = 1'b0;
    mem_q.delete(); sb.delete();
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; base = 0; lat = 0;
    man_rv = 1'b0; man_expect = 1'b0; man_addr = '0;
    i_rst = 1'b1; i_req = '0; i_mm_gnt = 1'b0; i_mm_rvalid = 1'b0; i_mm_rdata = '0;
    for (int k = 0; k < 4; k++) addr_tab[k] = 32'h8000_0000 + 32'(k) * 32'h0000_0440 + 32'h20;

    // {req, gnt pattern (bit j = gnt at edge j), latency, window, grants, resps}
    tbl[0] = '{req: 4'b0101, gnt: 8'hff, lat: 3, win: 8, ng: 4, nr: 2,
               gid: {2'd0, 2'd2, 2'd0, 2'd2, 2'd0}, gcyc: {4'd0, 4'd5, 4'd4, 4'd1, 4'd0},
               rvec: {4'b0000, 4'b0000, 4'b0100, 4'b0001}, busy: 1'b1, pend: 4'b0100};
    tbl[1] = '{req: 4'b1111, gnt: 8'b1111_1101, lat: 1, win: 6, ng: 5, nr: 4,
               gid: {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, gcyc: {4'd5, 4'd4, 4'd3, 4'd2, 4'd0},
               rvec: {4'b1000, 4'b0100, 4'b0010, 4'b0001}, busy: 1'b1, pend: 4'b0001};
    tbl[2] = '{req: 4'b1111, gnt: 8'hff, lat: 0, win: 10, ng: 2, nr: 0,
               gid: {2'd0, 2'd0, 2'd0, 2'd1, 2'd0}, gcyc: {4'd0, 4'd0, 4'd0, 4'd1, 4'd0},
               rvec: '0, busy: 1'b1, pend: 4'b0011};

    do_reset();
    chk("rst_rden", o_mm_rden, 0);
    chk("rst_addr", o_mm_addr, 0);
    chk("rst_ack", o_req_ack, 0);
    chk("rst_resp", o_resp_valid, 0);
    chk("rst_data", o_resp_data, 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);

    // rvalid with nothing outstanding
    man_rv = 1'b1; man_expect = 1'b0; man_addr = addr_tab[3];
    tick();
    tick();
    chk("orphan_err", o_err, 2'b01);
    chk("orphan_resp", o_resp_valid, 0);
    chk("orphan_busy", o_busy, 0);
    chk("orphan_pending", o_pending, 0);

    for (int i = 0; i < 3; i++) begin
      do_reset();
      i_req = tbl[i].req;
      lat   = tbl[i].lat;
      grants.delete(); gcyc.delete(); resps.delete();
      base = cyc + 1;
      i_mm_gnt = tbl[i].gnt[0];
      for (int r = 0; r < int'(tbl[i].win); r++) begin
        tick();
        i_mm_gnt = (r + 1 < 8) ? tbl[i].gnt[r + 1] : 1'b1;
      end
      chk($sformatf("row%0d_grant_count", i), 128'(grants.size()), 128'(tbl[i].ng));
      for (int g = 0; g < int'(tbl[i].ng) && g < grants.size(); g++) begin
        chk($sformatf("row%0d_grant%0d_id", i, g), 128'(grants[g]), 128'(tbl[i].gid[g]));
        chk($sformatf("row%0d_grant%0d_cycle", i, g), 128'(gcyc[g]), 128'(tbl[i].gcyc[g]));
      end
      if (tbl[i].nr != 0) begin
        chk($sformatf("row%0d_resp_count", i), 128'(resps.size() >= int'(tbl[i].nr)), 1);
        for (int g = 0; g < int'(tbl[i].nr) && g < resps.size(); g++)
          chk($sformatf("row%0d_resp%0d", i, g), resps[g], tbl[i].rvec[g]);
      end
      chk($sformatf("row%0d_busy", i), o_busy, tbl[i].busy);
      chk($sformatf("row%0d_pending", i), o_pending, tbl[i].pend);
      chk($sformatf("row%0d_err", i), o_err, 0);
    end

    // Reset with two reads outstanding (left by the last table row); a late rvalid follows.
    i_rst = 1'b1; man_rv = 1'b1; man_expect = 1'b0; man_addr = addr_tab[0];
    sb.delete(); mem_q.delete();
    tick();
    chk("midrst_rden", o_mm_rden, 0);
    chk("midrst_addr", o_mm_addr, 0);
    chk("midrst_ack", o_req_ack, 0);
    chk("midrst_resp", o_resp_valid, 0);
    chk("midrst_data", o_resp_data, 0);
    chk("midrst_pending", o_pending, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_err", o_err, 0);
    i_rst = 1'b0;
    tick();
    chk("postrst_ack", o_req_ack, 4'b0001);
    chk("postrst_err", o_err, 2'b01);
    chk("postrst_resp", o_resp_valid, 0);

    // Watchdog: one read to PE1, memory silent
    do_reset();
    lat = 0; i_req = 4'b0010; i_mm_gnt = 1'b1;
    tick();
    chk("wd_ack", o_req_ack, 4'b0010);
    repeat (254) tick();
    chk("wd_before_timeout", o_err, 2'b00);
    tick();
    chk("wd_timeout", o_err, 2'b10);
    chk("wd_still_pending", o_pending, 4'b0010);
    man_rv = 1'b1; man_expect = 1'b1; man_addr = addr_tab[1];
    tick();
    tick();
    chk("wd_late_resp_seen", 128'(resps.size() > 0 ? resps[resps.size() - 1] : 4'b0000), 4'b0010);
    chk("wd_err_sticky", o_err, 2'b10);
    i_req = '0;
    tick();
    chk("wd_pending_clear", o_pending, 0);
    chk("wd_busy_clear", o_busy, 0);
    chk("sb_drained", 128'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
